// File: rtl/map_sampler_if.sv
// Pixel-request stream, result stream and host map-write/fill signals of map_sampler.
// The master side drives requests and host writes; the slave side is the sampler.
`timescale 1ns/1ps
interface map_sampler_if #(
  parameter int MAP_AW = 15,
  parameter int ID_W   = 4,
  parameter int UV_W   = 9,
  parameter int TEX_DW = 16,
  parameter int PIX_AW = 20
);
  logic              write_en;
  logic [MAP_AW-1:0] write_addr;
  logic [ID_W-1:0]   write_data;
  logic              fill_start;
  logic [ID_W-1:0]   fill_id;
  logic              busy;
  logic              fill_done;
  logic              in_valid;
  logic              in_ready;
  logic [MAP_AW-1:0] block_addr;
  logic [UV_W-1:0]   uv;
  logic [PIX_AW-1:0] pixel_addr;
  logic              out_valid;
  logic              out_ready;
  logic [PIX_AW-1:0] out_addr;
  logic [TEX_DW-1:0] out_data;
  logic [ID_W-1:0]   out_id;

  modport master (
    output write_en, write_addr, write_data, fill_start, fill_id,
    output in_valid, block_addr, uv, pixel_addr, out_ready,
    input  busy, fill_done, in_ready, out_valid, out_addr, out_data, out_id
  );

  modport slave (
    input  write_en, write_addr, write_data, fill_start, fill_id,
    input  in_valid, block_addr, uv, pixel_addr, out_ready,
    output busy, fill_done, in_ready, out_valid, out_addr, out_data, out_id
  );
endinterface

// File: rtl/map_sampler.sv
// Map/texture lookup stage: block-ID map RAM plus texture ROM behind a
// valid/ready pipeline, with bulk map fill and host write-to-read forwarding.
`timescale 1ns/1ps
module map_sampler #(
  parameter int               MAP_AW         = 15,
  parameter int               ID_W           = 4,
  parameter int               UV_W           = 9,
  parameter int               TEX_DW         = 16,
  parameter int               PIX_AW         = 20,
  parameter logic [ID_W-1:0]  TRANSPARENT_ID = '0,
  parameter logic [TEX_DW-1:0] BG_COLOR      = TEX_DW'(16'h867D)
) (
  input  logic          clk,
  input  logic          rst_n,
  map_sampler_if.slave  bus
);

  localparam int ROM_AW    = ID_W + UV_W;
  localparam int MAP_DEPTH = 1 << MAP_AW;

  typedef enum logic {S_IDLE, S_FILL} fill_state_t;

  // Texture contents are a fixed hash of the texel address, read through a register.
  function automatic logic [TEX_DW-1:0] tex_rom(input logic [ROM_AW-1:0] a);
    logic [31:0] t;
    t = 32'(a) * 32'd40503 + 32'd4660;
    t = t ^ (t >> 7);
    return t[TEX_DW-1:0];
  endfunction

  fill_state_t       r_state;
  logic              r_busy;
  logic              r_fill_done;
  logic [MAP_AW:0]   r_cnt;
  logic [ID_W-1:0]   r_fill_id;
  logic [MAP_AW:0]   w_cnt_next;

  logic [ID_W-1:0]   r_map [0:MAP_DEPTH-1];
  logic [ID_W-1:0]   r_map_dout;
  logic              w_wr_en;
  logic [MAP_AW-1:0] w_wr_addr;
  logic [ID_W-1:0]   w_wr_data;
  logic              w_host_wr;

  logic              w_adv;
  logic              w_accept;
  logic              r_s1_valid;
  logic [UV_W-1:0]   r_uv_s1;
  logic [PIX_AW-1:0] r_pix_s1;
  logic              r_fwd_hit;
  logic [ID_W-1:0]   r_fwd_data;
  logic [ID_W-1:0]   w_id_s1;

  logic              r_s2_valid;
  logic [ID_W-1:0]   r_id_s2;
  logic [PIX_AW-1:0] r_pix_s2;
  logic [TEX_DW-1:0] r_rom_dout;

  logic              r_out_valid;
  logic [PIX_AW-1:0] r_out_addr;
  logic [TEX_DW-1:0] r_out_data;
  logic [ID_W-1:0]   r_out_id;

  assign w_adv     = ~r_out_valid | bus.out_ready;
  assign w_accept  = bus.in_valid & w_adv & ~r_busy;
  assign w_host_wr = bus.write_en & ~r_busy;

  // The fill owns the write port while busy; host writes are dropped then.
  assign w_wr_en   = r_busy | w_host_wr;
  assign w_wr_addr = r_busy ? r_cnt[MAP_AW-1:0] : bus.write_addr;
  assign w_wr_data = r_busy ? r_fill_id : bus.write_data;

  assign w_cnt_next = r_cnt + (MAP_AW+1)'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_fill_done <= 1'b0;
      r_cnt       <= '0;
      r_fill_id   <= '0;
    end else begin
      r_fill_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.fill_start) begin
            r_fill_id <= bus.fill_id;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= S_FILL;
          end
        end
        S_FILL: begin
          r_cnt <= w_cnt_next;
          // Carry into the extra counter bit marks the write of the last cell.
          if (w_cnt_next[MAP_AW]) begin
            r_busy      <= 1'b0;
            r_fill_done <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-before-write RAM; a same-edge host hit is patched in S1 from r_fwd_*.
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_map[w_wr_addr] <= w_wr_data;
    if (w_adv)
      r_map_dout <= r_map[bus.block_addr];
  end

  assign w_id_s1 = r_fwd_hit ? r_fwd_data : r_map_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_uv_s1     <= '0;
      r_pix_s1    <= '0;
      r_fwd_hit   <= 1'b0;
      r_fwd_data  <= '0;
      r_s2_valid  <= 1'b0;
      r_id_s2     <= '0;
      r_pix_s2    <= '0;
      r_rom_dout  <= '0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else if (w_adv) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_uv_s1    <= bus.uv;
        r_pix_s1   <= bus.pixel_addr;
        r_fwd_hit  <= w_host_wr & (bus.write_addr == bus.block_addr);
        r_fwd_data <= bus.write_data;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_id_s2    <= w_id_s1;
        r_pix_s2   <= r_pix_s1;
        r_rom_dout <= tex_rom({w_id_s1, r_uv_s1});
      end
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_id   <= r_id_s2;
        r_out_addr <= r_pix_s2;
        r_out_data <= (r_id_s2 == TRANSPARENT_ID) ? BG_COLOR : r_rom_dout;
      end
    end
  end

  assign bus.in_ready  = w_adv & ~r_busy;
  assign bus.busy      = r_busy;
  assign bus.fill_done = r_fill_done;
  assign bus.out_valid = r_out_valid;
  assign bus.out_addr  = r_out_addr;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;

endmodule

// File: tb/tb_map_sampler.sv
// Scoreboard bench for map_sampler: expected results are queued at request
// acceptance from a shadow map model and compared as results leave the DUT.
`timescale 1ns/1ps
module tb_map_sampler;
  localparam int MAP_AW    = 15;
  localparam int ID_W      = 4;
  localparam int UV_W      = 9;
  localparam int TEX_DW    = 16;
  localparam int PIX_AW    = 20;
  localparam int MAP_DEPTH = 1 << MAP_AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  map_sampler_if #(.MAP_AW(MAP_AW), .ID_W(ID_W), .UV_W(UV_W), .TEX_DW(TEX_DW), .PIX_AW(PIX_AW)) bus ();

  map_sampler #(.MAP_AW(MAP_AW), .ID_W(ID_W), .UV_W(UV_W), .TEX_DW(TEX_DW), .PIX_AW(PIX_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [PIX_AW-1:0] pix;
    logic [ID_W-1:0]   id;
    logic [TEX_DW-1:0] data;
  } exp_t;

  exp_t            sb[$];
  logic [ID_W-1:0] mdl_map [MAP_DEPTH];
  int              n_checks = 0;
  int              n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TEX_DW-1:0] exp_color(input int unsigned id, input int unsigned uvv);
    int unsigned x;
    if (id == 0) return 16'h867D;
    x = (id * 512 + uvv) * 40503 + 4660;
    x = x ^ (x >> 7);
    return x[15:0];
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid) begin
      if (bus.out_ready) begin
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          $display("OUT addr=%0d id=%0d data=%h exp_addr=%0d exp_id=%0d exp_data=%h",
                   bus.out_addr, bus.out_id, bus.out_data, e.pix, e.id, e.data);
          chk("out_addr", 32'(bus.out_addr), 32'(e.pix));
          chk("out_id",   32'(bus.out_id),   32'(e.id));
          chk("out_data", 32'(bus.out_data), 32'(e.data));
        end
      end else begin
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        if (sb.size() != 0) begin
          chk("stall_addr", 32'(bus.out_addr), 32'(sb[0].pix));
          chk("stall_data", 32'(bus.out_data), 32'(sb[0].data));
        end
      end
    end
  end

  task automatic host_write(input int addr, input int data);
    bus.write_en   = 1'b1;
    bus.write_addr = MAP_AW'(addr);
    bus.write_data = ID_W'(data);
    @(posedge clk); #1;
    bus.write_en = 1'b0;
    mdl_map[MAP_AW'(addr)] = ID_W'(data);
  endtask

  task automatic send_req(input int addr, input int uvv, input int pix,
                          input bit wr, input int waddr, input int wdata);
    bit              acc;
    exp_t            e;
    logic [ID_W-1:0] id;
    acc = 1'b0;
    bus.in_valid   = 1'b1;
    bus.block_addr = MAP_AW'(addr);
    bus.uv         = UV_W'(uvv);
    bus.pixel_addr = PIX_AW'(pix);
    bus.write_en   = wr;
    bus.write_addr = MAP_AW'(waddr);
    bus.write_data = ID_W'(wdata);
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = 1'b1;
        id = (wr && waddr == addr) ? ID_W'(wdata) : mdl_map[MAP_AW'(addr)];
        e.pix  = PIX_AW'(pix);
        e.id   = id;
        e.data = exp_color(int'(id), uvv);
        sb.push_back(e);
        $display("REQ addr=%0d uv=%0h pix=%0d wr=%0d exp_id=%0d", addr, uvv, pix, wr, id);
      end
      @(posedge clk); #1;
    end
    if (wr && acc) mdl_map[MAP_AW'(waddr)] = ID_W'(wdata);
    bus.in_valid = 1'b0;
    bus.write_en = 1'b0;
    chk("req_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt, done_cnt, viol, done_i;
    bus.write_en = 0; bus.write_addr = '0; bus.write_data = '0;
    bus.fill_start = 0; bus.fill_id = '0;
    bus.in_valid = 0; bus.block_addr = '0; bus.uv = '0; bus.pixel_addr = '0;
    bus.out_ready = 1;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_addr",  32'(bus.out_addr),  32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_id",    32'(bus.out_id),    32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_fill_done", 32'(bus.fill_done), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);

    // basic lookup and latency
    host_write(5, 3);
    send_req(5, 'h012, 100, 0, 0, 0);
    @(posedge clk); #1;
    chk("lat_edge1_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge2_valid", 32'(bus.out_valid), 32'd1);
    wait_drain();

    // transparent block
    host_write(7, 0);
    send_req(7, 'h1AB, 101, 0, 0, 0);
    wait_drain();

    // same-edge write forwarding
    host_write(9, 1);
    send_req(9, 'h033, 102, 1, 9, 6);
    wait_drain();

    // random cells with occasional same-edge writes
    for (int a = 16; a < 32; a++) host_write(a, int'($urandom_range(0, 15)));
    for (int k = 0; k < 8; k++)
      send_req(int'($urandom_range(16, 31)), int'($urandom_range(0, 511)), 200 + k,
               bit'($urandom_range(0, 1)), int'($urandom_range(16, 31)), int'($urandom_range(0, 15)));
    wait_drain();

    // back-to-back stream with downstream stall
    fork
      begin
        for (int p = 0; p < 5; p++) send_req(16 + p, p * 7, p, 0, 0, 0);
      end
      begin
        for (int i = 0; i < 50; i++) begin
          @(posedge clk); #1;
          if (bus.out_valid) break;
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // full fill; a pixel accepted just before keeps its pre-fill id
    send_req(5, 'h044, 300, 0, 0, 0);
    bus.fill_start = 1'b1; bus.fill_id = 4'd2;
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    busy_cnt = 0; done_cnt = 0; viol = 0; done_i = -1;
    for (int i = 0; i < 40000; i++) begin
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.in_ready) viol++;
      if (bus.fill_done) begin
        done_cnt++;
        done_i = i;
        if (bus.busy) viol++;
      end
      if (i == 100) begin
        bus.write_en = 1'b1; bus.write_addr = 15'd100; bus.write_data = 4'd9;
      end
      if (i == 101) bus.write_en = 1'b0;
      if (i == 200) begin
        bus.fill_start = 1'b1; bus.fill_id = 4'd7;
      end
      if (i == 201) bus.fill_start = 1'b0;
      if (done_i >= 0 && i > done_i + 3) break;
      @(posedge clk); #1;
    end
    chk("fill_busy_cycles", 32'(busy_cnt), 32'd32768);
    chk("fill_done_pulses", 32'(done_cnt), 32'd1);
    chk("fill_violations",  32'(viol),     32'd0);
    foreach (mdl_map[i]) mdl_map[i] = 4'd2;
    wait_drain();
    send_req(0,     'h001, 500, 0, 0, 0);
    send_req(5,     'h0F0, 501, 0, 0, 0);
    send_req(32767, 'h1FF, 502, 0, 0, 0);
    send_req(100,   'h100, 503, 0, 0, 0);
    wait_drain();

    // reset in the middle of a fill, with a result stalled at the output
    host_write(0, 5);
    host_write(20000, 11);
    bus.out_ready = 1'b0;
    send_req(0, 'h055, 400, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    bus.fill_start = 1'b1; bus.fill_id = 4'd4;
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    repeat (999) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstfill_busy",      32'(bus.busy),      32'd0);
    chk("rstfill_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rstfill_out_data",  32'(bus.out_data),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    bus.out_ready = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.fill_done || bus.busy) done_cnt++;
      @(posedge clk); #1;
    end
    chk("rstfill_no_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < 900; i++) mdl_map[i] = 4'd4;
    send_req(0,     'h077, 600, 0, 0, 0);
    send_req(20000, 'h078, 601, 0, 0, 0);
    send_req(899,   'h079, 602, 0, 0, 0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/map_sampler.md
Name: map_sampler

Overview:
- Parametrised successor of the map/texture lookup stage in the voxel renderer.
- Holds the block-ID map RAM (host-writable) and the texture ROM.
- Turns a pixel request (block address + texel offset + pixel address) into a colour, through a 2-stage pipeline with valid/ready backpressure.
- Adds map bulk-fill, write-to-read forwarding and a transparent-block background colour.

Parameters:
- MAP_AW, 15, map RAM address width (depth 2^MAP_AW).
- ID_W, 4, block ID width.
- UV_W, 9, texel offset width inside one block texture; ROM address = {block_id, uv}, width ID_W+UV_W.
- TEX_DW, 16, texel/colour width (RGB565).
- PIX_AW, 20, pixel address width carried alongside the data.
- TRANSPARENT_ID, 0, block ID rendered as BG_COLOR.
- BG_COLOR, 16'h867D, colour output for TRANSPARENT_ID.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- write_en  in  1  host map write strobe.
- write_addr  in  MAP_AW  host map write address.
- write_data  in  ID_W  host map write data.
- fill_start  in  1  pulse: start bulk fill of whole map.
- fill_id  in  ID_W  fill value, sampled with fill_start.
- busy  out  1  fill in progress.
- fill_done  out  1  one-cycle pulse at fill end.
- in_valid  in  1  pixel request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- block_addr  in  MAP_AW  map cell of the pixel.
- uv  in  UV_W  texel offset.
- pixel_addr  in  PIX_AW  framebuffer address, passed through.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_addr  out  PIX_AW  pixel_addr of the result.
- out_data  out  TEX_DW  colour.
- out_id  out  ID_W  block ID that produced the colour.

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, out_addr=0, out_data=0, out_id=0, busy=0, fill_done=0.
  - Pipeline valids cleared; FSM goes to IDLE.
  - Map RAM contents are not reset.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv & !busy (combinational).
- All stage registers, the map RAM read port and the ROM clock-enable hold when adv=0. Data is never lost or duplicated under backpressure.
- S0 (accept edge): map RAM synchronous read of block_addr. uv and pixel_addr registered into S1.
- S1:
  - id = RAM dout. If a host write hit block_addr on the accept edge, id = write_data (write-first forwarding).
  - ROM addressed with {id, uv_s1}; id and pixel_addr registered into S2.
- S2: out_data = (id==TRANSPARENT_ID) ? BG_COLOR : ROM dout. out_valid set.
- Latency: accept edge to out_valid = 2 clk with out_ready held high. Throughput is 1 pixel/clk.
- Map contents seen by a request are those at its accept edge. Later writes do not affect in-flight pixels.
- Host write: performed on any clk edge with write_en=1 while busy=0. Ignored (dropped) while busy=1.
- Fill FSM:
  - IDLE: fill_start=1 latches fill_id, clears the counter, and moves to FILL on the next edge.
    - If write_en is also high on that edge, the host write still completes; the fill later overwrites it.
  - FILL: busy=1. Writes fill_id to address cnt, then cnt+1, one per clk, from 0 to 2^MAP_AW-1.
    - On the write of the last address, pulse fill_done next cycle and return to IDLE.
    - Fill takes exactly 2^MAP_AW cycles; no wrap of cnt beyond the last address.
  - fill_start during FILL is ignored.
  - In-flight pixels accepted before busy rose complete normally, with their pre-fill IDs.
- Reset mid-fill: FSM returns to IDLE, busy=0, no fill_done pulse. Map is partially filled.
- Width rules: all addresses unsigned, no arithmetic on data. The counter is MAP_AW+1 bits internally to detect the end.

Test Plan:
- After reset, write_addr=5, write_data=3. Request block_addr=5, uv=9'h012, pixel_addr=100 with out_ready=1 → 2 clk later out_valid=1, out_id=3, out_addr=100, out_data=ROM[{4'd3,9'h012}].
- Map cell 7 = TRANSPARENT_ID (0), request it → out_data=16'h867D, out_id=0.
- Same edge: write_en with addr 9, data 6, plus accepted request to block_addr 9 → out_id=6 (forwarded, not the stale value).
- Stream 5 requests (pixel_addr 0..4); hold out_ready=0 for 3 cycles after the first result → in_ready=0 while stalled; out_addr sequence 0,1,2,3,4 with no loss or duplication; out_data stable while stalled.
- fill_start with fill_id=2 → busy=1 for 32768 cycles, in_ready=0, host write during fill dropped; fill_done single pulse. Afterwards requests to addresses 0, 5 and 32767 all return out_id=2.
- rst_n low for 1 cycle at fill cycle 1000 → busy=0 immediately, out_valid=0, no fill_done. Next request to address 0 returns out_id=fill_id; address 20000 keeps its old value.
